// File: rtl/stream_wrr_arbiter.sv
// Weighted round-robin stream arbiter.
// Shares one valid/ready output among NumInp inputs. Input i may take up to
// weight_i[i] consecutive beats before priority rotates; a weight of 0 counts
// as 1. The datapath is combinational. A stalled grant is locked until its
// handshake completes.
// Optional feature macro: COMMON_CELLS_WRR_GRANT_CNT_EN adds grant_cnt_o, a
// 16-bit saturating handshake counter per input.
module stream_wrr_arbiter #(
  parameter int unsigned NumInp      = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter int unsigned IdxWidth    = (NumInp > 1) ? $clog2(NumInp) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NumInp*WeightWidth-1:0] weight_i,
  input  logic [NumInp*DataWidth-1:0]   data_i,
  input  logic [NumInp-1:0]             valid_i,
  output logic [NumInp-1:0]             ready_o,
  output logic [DataWidth-1:0]          data_o,
  output logic [IdxWidth-1:0]           idx_o,
  output logic                          valid_o,
`ifdef COMMON_CELLS_WRR_GRANT_CNT_EN
  output logic [NumInp*16-1:0]          grant_cnt_o,
`endif
  input  logic                          ready_i
);

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_e;

  lock_e                                r_lock, w_lock_nxt;
  logic [IdxWidth-1:0]                  r_rr, w_rr_nxt;
  logic [IdxWidth-1:0]                  r_sel, w_sel_nxt;
  logic [WeightWidth-1:0]               r_cnt, w_cnt_nxt;
  logic [IdxWidth-1:0]                  w_arb;
  logic [IdxWidth-1:0]                  w_sel;
  logic                                 w_hs;
  logic [WeightWidth:0]                 w_cnt_inc;
  logic [WeightWidth:0]                 w_w;
  logic [NumInp-1:0][DataWidth-1:0]     w_data_arr;
  logic [NumInp-1:0][WeightWidth-1:0]   w_weight_arr;

  assign w_data_arr   = data_i;
  assign w_weight_arr = weight_i;

  // Modulo-NumInp increment; never produces an index above NumInp-1.
  function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] a);
    return (a == IdxWidth'(NumInp - 1)) ? '0 : a + IdxWidth'(1);
  endfunction

  // Priority search: first valid input starting at r_rr, wrapping around.
  always_comb begin
    logic                w_found;
    logic [IdxWidth-1:0] w_j;
    w_arb   = r_rr;
    w_found = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < NumInp; k++) begin
      w_j = IdxWidth'((32'(r_rr) + k) % NumInp);
      if (!w_found && valid_i[w_j]) begin
        w_arb   = w_j;
        w_found = 1'b1;
      end
    end
  end

  // Grant selection and output mux; a locked grant overrides the search.
  always_comb begin
    ready_o = '0;
    if (r_lock == ST_LOCKED) begin
      w_sel   = r_sel;
      valid_o = valid_i[r_sel];
    end else begin
      w_sel   = w_arb;
      valid_o = |valid_i;
    end
    data_o = w_data_arr[w_sel];
    idx_o  = w_sel;
    if (valid_o && ready_i) begin
      ready_o[w_sel] = 1'b1;
    end
  end

  assign w_hs      = valid_o & ready_i;
  assign w_cnt_inc = {1'b0, r_cnt} + (WeightWidth + 1)'(1);
  assign w_w       = (w_weight_arr[w_sel] == '0) ? (WeightWidth + 1)'(1)
                                                  : {1'b0, w_weight_arr[w_sel]};

  // Next scheduling state: weight accounting on handshake, lock on stall,
  // flush overrides both.
  always_comb begin
    w_rr_nxt   = r_rr;
    w_cnt_nxt  = r_cnt;
    w_lock_nxt = r_lock;
    w_sel_nxt  = r_sel;
    if (w_hs) begin
      w_lock_nxt = ST_FREE;
      if (w_sel == r_rr) begin
        if (w_cnt_inc >= w_w) begin
          w_rr_nxt  = wrap_inc(w_sel);
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc[WeightWidth-1:0];
        end
      end else if (w_w == (WeightWidth + 1)'(1)) begin
        w_rr_nxt  = wrap_inc(w_sel);
        w_cnt_nxt = '0;
      end else begin
        // The priority input was idle: the granted input starts its own turn
        // with this beat already counted.
        w_rr_nxt  = w_sel;
        w_cnt_nxt = WeightWidth'(1);
      end
    end else if (valid_o) begin
      w_lock_nxt = ST_LOCKED;
      w_sel_nxt  = w_sel;
    end
    if (flush_i) begin
      w_rr_nxt   = '0;
      w_cnt_nxt  = '0;
      w_lock_nxt = ST_FREE;
    end
  end

  // Scheduling state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rr   <= '0;
      r_cnt  <= '0;
      r_lock <= ST_FREE;
      r_sel  <= '0;
    end else begin
      r_rr   <= w_rr_nxt;
      r_cnt  <= w_cnt_nxt;
      r_lock <= w_lock_nxt;
      r_sel  <= w_sel_nxt;
    end
  end

`ifdef COMMON_CELLS_WRR_GRANT_CNT_EN
  logic [NumInp-1:0][15:0] r_gcnt;

  // Per-input saturating handshake counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_gcnt <= '0;
    end else if (flush_i) begin
      r_gcnt <= '0;
    end else if (w_hs && (r_gcnt[w_sel] != '1)) begin
      r_gcnt[w_sel] <= r_gcnt[w_sel] + 16'd1;
    end
  end

  assign grant_cnt_o = r_gcnt;
`endif

endmodule

// File: tb/tb_stream_wrr_arbiter.sv
// Self-checking bench for stream_wrr_arbiter (NumInp=4, WeightWidth=4).
// Expected outputs come from a behavioural reference model and are queued
// when stimulus is applied, then compared when the outputs are sampled.
module tb_stream_wrr_arbiter;

  localparam int NI = 4;
  localparam int DW = 32;
  localparam int WW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [NI-1:0][WW-1:0]  tb_w;
  logic [NI-1:0][DW-1:0]  tb_data;
  logic [NI-1:0]          valid_in;
  logic [NI-1:0]          ready_out;
  logic [DW-1:0]          data_out;
  logic [1:0]             idx_out;
  logic                   valid_out;
  logic                   ready_in;
`ifdef COMMON_CELLS_WRR_GRANT_CNT_EN
  logic [NI*16-1:0]       gcnt;
`endif

  stream_wrr_arbiter #(
    .NumInp      (NI),
    .DataWidth   (DW),
    .WeightWidth (WW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .weight_i    (tb_w),
    .data_i      (tb_data),
    .valid_i     (valid_in),
    .ready_o     (ready_out),
    .data_o      (data_out),
    .idx_o       (idx_out),
    .valid_o     (valid_out),
`ifdef COMMON_CELLS_WRR_GRANT_CNT_EN
    .grant_cnt_o (gcnt),
`endif
    .ready_i     (ready_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [1:0]    idx;
    logic [DW-1:0] data;
    logic [NI-1:0] rdy;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model state
  int   m_rr, m_cnt, m_sel;
  bit   m_lock;
  logic [1:0]    last_idx;
  logic [NI-1:0] last_rdy;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_cnt = 0; m_sel = 0; m_lock = 0;
  endtask

  // One clock of stimulus: predict, queue, sample at negedge, compare, then
  // advance the model across the rising edge.
  task automatic step();
    exp_t e;
    int   s;
    int   w;
    bit   v;
    if (m_lock) begin
      s = m_sel;
      v = valid_in[s];
    end else begin
      v = |valid_in;
      s = m_rr;
      for (int k = NI - 1; k >= 0; k--)
        if (valid_in[(m_rr + k) % NI]) s = (m_rr + k) % NI;
    end
    e.v    = v;
    e.idx  = 2'(s);
    e.data = tb_data[s];
    e.rdy  = (v && ready_in) ? NI'(1 << s) : '0;
    q.push_back(e);

    @(negedge clk);
    e = q.pop_front();
    check_eq("valid_o", {63'd0, valid_out}, {63'd0, e.v});
    check_eq("ready_o", {60'd0, ready_out}, {60'd0, e.rdy});
    if (e.v) begin
      check_eq("idx_o", {62'd0, idx_out}, {62'd0, e.idx});
      check_eq("data_o", {32'd0, data_out}, {32'd0, e.data});
    end
    last_idx = idx_out;
    last_rdy = ready_out;

    if (flush) begin
      m_rr = 0; m_cnt = 0; m_lock = 0;
    end else if (v && ready_in) begin
      m_lock = 0;
      w = (tb_w[s] == 0) ? 1 : int'(tb_w[s]);
      if (s == m_rr) begin
        if (m_cnt + 1 >= w) begin
          m_rr = (s + 1) % NI; m_cnt = 0;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end else if (w == 1) begin
        m_rr = (s + 1) % NI; m_cnt = 0;
      end else begin
        m_rr = s; m_cnt = 1;
      end
    end else if (v) begin
      m_lock = 1;
      m_sel  = s;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    valid_in = '0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
  endtask

  int seq1[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int seq2[10] = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
  int seq5[5]  = '{0, 0, 0, 0, 1};

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    valid_in = '0;
    ready_in = 1'b0;
    tb_w     = '0;
    for (int i = 0; i < NI; i++) tb_data[i] = 32'hA000_0000 + 32'(i);
    model_reset();
    #23;
    // Outputs with reset held and no valid input.
    check_eq("rst_valid", {63'd0, valid_out}, 64'd0);
    check_eq("rst_ready", {60'd0, ready_out}, 64'd0);
    check_eq("rst_idx", {62'd0, idx_out}, 64'd0);
    check_eq("rst_data", {32'd0, data_out}, 64'hA000_0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Plain round robin with unit weights.
    tb_w     = {4'd1, 4'd1, 4'd1, 4'd1};
    valid_in = '1;
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("rr_seq", {62'd0, last_idx}, 64'(seq1[i]));
    end

    // Weights {3,1,2,1}.
    do_flush();
    tb_w     = {4'd1, 4'd2, 4'd1, 4'd3};
    valid_in = '1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("wrr_seq", {62'd0, last_idx}, 64'(seq2[i]));
    end

    // Lock-in: stalled grant on input 2 must hold against input 0.
    do_flush();
    tb_w     = {4'd1, 4'd1, 4'd1, 4'd1};
    valid_in = 4'b0100;
    ready_in = 1'b0;
    repeat (3) begin
      step();
      check_eq("lock_idx", {62'd0, last_idx}, 64'd2);
      check_eq("lock_rdy", {60'd0, last_rdy}, 64'd0);
    end
    valid_in = 4'b0101;
    step();
    check_eq("lock_hold", {62'd0, last_idx}, 64'd2);
    ready_in = 1'b1;
    step();
    check_eq("lock_hs", {60'd0, last_rdy}, 64'b0100);
    step();
    check_eq("lock_rel", {62'd0, last_idx}, 64'd0);

    // Zero weight behaves as one.
    do_flush();
    tb_w     = {4'd1, 4'd1, 4'd0, 4'd1};
    valid_in = 4'b0010;
    repeat (4) begin
      step();
      check_eq("w0_idx", {62'd0, last_idx}, 64'd1);
    end

    // Flush in the middle of input 0's turn restarts the turn.
    do_flush();
    tb_w     = {4'd1, 4'd1, 4'd1, 4'd4};
    valid_in = '1;
    step();
    step();
    do_flush();
    valid_in = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("flush_seq", {62'd0, last_idx}, 64'(seq5[i]));
    end

    // Randomised traffic against the model.
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < NI; j++) tb_data[j] = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        do_flush();
      end else begin
        valid_in = 4'($urandom);
        ready_in = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 7) == 0)
          for (int j = 0; j < NI; j++) tb_w[j] = 4'($urandom_range(0, 4));
        step();
      end
    end

    // Asynchronous reset while locked on input 2.
    do_flush();
    tb_w     = {4'd1, 4'd1, 4'd1, 4'd1};
    valid_in = 4'b0100;
    ready_in = 1'b0;
    step();
    valid_in = 4'b0101;
    #2;
    check_eq("pre_rst_idx", {62'd0, idx_out}, 64'd2);
    rst = 1'b1;
    #1;
    check_eq("async_rst_idx", {62'd0, idx_out}, 64'd0);
    check_eq("async_rst_vld", {63'd0, valid_out}, 64'd1);
    valid_in = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    valid_in = 4'b1010;
    ready_in = 1'b1;
    repeat (4) step();

`ifdef COMMON_CELLS_WRR_GRANT_CNT_EN
    // Saturation of the grant counter for input 3.
    do_flush();
    valid_in = 4'b1000;
    ready_in = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    check_eq("gcnt3_sat", {48'd0, gcnt[63:48]}, 64'hFFFF);
    check_eq("gcnt_other", {16'd0, gcnt[47:0]}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("gcnt_rst", gcnt, 64'd0);
    valid_in = '0;
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
